// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush scheduler for the 5-stage core.
// Combines load-use hazards, EX redirects, data-memory wait states and
// a multi-cycle mul/div sequencer into per-stage write/flush controls,
// and keeps stall and redirect-flush performance counters.
module pipeline_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_id_instruction,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_muldiv,
    input  logic        id_ex_is_div,
    input  logic        ex_redirect,
    input  logic        ex_mem_memaccess,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       flush_cnt_q;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       lu;
    logic       ms;
    logic       redirect_take;
    logic       unused_instr_bits;

    assign opcode = if_id_instruction[6:0];
    assign rs1    = if_id_instruction[19:15];
    assign rs2    = if_id_instruction[24:20];
    assign unused_instr_bits = ^{if_id_instruction[31:25], if_id_instruction[14:7]};

    // Decode which source fields of the ID instruction are real register reads
    always_comb begin
        rs1_used = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
        rs2_used = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);
        lu = id_ex_memread && (id_ex_rd != 5'd0) &&
             ((id_ex_rd == rs1 && rs1_used) || (id_ex_rd == rs2 && rs2_used));
        ms = ex_mem_memaccess && !dmem_ready;
        redirect_take = rst_n && !ms && (state == RUN) && !id_ex_muldiv && ex_redirect;
    end

    // Prioritised control outputs: reset, memory stall, mul/div, redirect, load-use
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        muldiv_start = 1'b0;
        muldiv_busy  = rst_n && (state == MD_WAIT);
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (ms) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (state == MD_WAIT) begin
            if (cnt != '0) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
            end
        end else if (id_ex_muldiv) begin
            muldiv_start = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Mul/div sequencer: cnt counts down the remaining EX cycles, release waits out memory stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!ms && id_ex_muldiv) begin
                        state <= MD_WAIT;
                        cnt   <= id_ex_is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!ms) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Performance counters: stalled PC cycles and taken redirect flushes, both wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_take) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl
// against a cycle-level behavioural model kept in the bench.
module tb_pipeline_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 33;

    localparam logic [31:0] ADD_X6 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X5 = {12'h000, 5'd5, 3'd0, 5'd5, 7'b0110111};
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic muldiv_start;
        logic muldiv_busy;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_id_instruction = NOP;
    logic        id_ex_memread = 1'b0;
    logic [4:0]  id_ex_rd = 5'd0;
    logic        id_ex_muldiv = 1'b0;
    logic        id_ex_is_div = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        ex_mem_memaccess = 1'b0;
    logic        dmem_ready = 1'b1;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_write;
    logic        id_ex_flush;
    logic        ex_mem_write;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        muldiv_start;
    logic        muldiv_busy;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int vectors = 0;
    int miscompares = 0;

    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;
    bit          preloadPending = 1'b0;

    pipeline_ctrl #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_id_instruction(if_id_instruction),
        .id_ex_memread(id_ex_memread),
        .id_ex_rd(id_ex_rd),
        .id_ex_muldiv(id_ex_muldiv),
        .id_ex_is_div(id_ex_is_div),
        .ex_redirect(ex_redirect),
        .ex_mem_memaccess(ex_mem_memaccess),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write),
        .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .muldiv_start(muldiv_start),
        .muldiv_busy(muldiv_busy),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Hazard rule: the EX load's destination is read by the ID instruction
    function automatic bit loadUse();
        logic [6:0] op;
        bit r1, r2;
        op = if_id_instruction[6:0];
        r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return id_ex_memread && id_ex_rd != 5'd0 &&
               ((id_ex_rd == if_id_instruction[19:15] && r1) ||
                (id_ex_rd == if_id_instruction[24:20] && r2));
    endfunction

    function automatic bit memStall();
        return ex_mem_memaccess && !dmem_ready;
    endfunction

    // Expected controls derived from the current inputs and the model's mul/div progress
    function automatic ctrl_t modelCtrl();
        ctrl_t c;
        c = '{1, 1, 0, 1, 0, 1, 0, 0, 0, 0};
        if (!rst_n) begin
            c = '{0, 0, 1, 0, 1, 0, 1, 1, 0, 0};
            return c;
        end
        c.muldiv_busy = m_busy;
        if (memStall()) begin
            c.pc_write = 0; c.if_id_write = 0; c.id_ex_write = 0; c.ex_mem_write = 0;
            c.mem_wb_flush = 1;
        end else if ((m_busy && m_left > 0) || (!m_busy && id_ex_muldiv)) begin
            c.pc_write = 0; c.if_id_write = 0; c.id_ex_write = 0; c.ex_mem_flush = 1;
            c.muldiv_start = !m_busy;
        end else if (!m_busy && ex_redirect) begin
            c.if_id_flush = 1; c.id_ex_flush = 1;
        end else if (!m_busy && loadUse()) begin
            c.pc_write = 0; c.if_id_write = 0; c.id_ex_flush = 1;
        end
        return c;
    endfunction

    // Model bookkeeping: cycles left in the mul/div, and the two counters
    always @(posedge clk or negedge rst_n) begin
        ctrl_t e;
        logic [31:0] base;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_stall <= 32'd0;
            m_flush <= 32'd0;
        end else begin
            e = modelCtrl();
            base = preloadPending ? 32'hFFFF_FFFF : m_stall;
            m_stall <= base + (e.pc_write ? 32'd0 : 32'd1);
            if (e.if_id_flush) m_flush <= m_flush + 32'd1;
            if (e.muldiv_start) begin
                m_busy <= 1'b1;
                m_left <= (id_ex_is_div ? DIV_N : MUL_N) - 1;
            end else if (m_busy) begin
                if (m_left > 0) m_left <= m_left - 1;
                else if (!memStall()) m_busy <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, mid-period, compare all DUT outputs with the model
    always @(negedge clk) begin
        ctrl_t exp, act;
        exp = modelCtrl();
        act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, mem_wb_flush, muldiv_start, muldiv_busy};
        checkOutput("ctrl", 32'(act), 32'(exp));
        checkOutput("stall_cycles", stall_cycles, preloadPending ? 32'hFFFF_FFFF : m_stall);
        checkOutput("flush_count", flush_count, m_flush);
    end

    task automatic applyStimulus(input logic [31:0] instr, input logic memread, input logic [4:0] rd,
                                 input logic md, input logic isdiv, input logic redir,
                                 input logic memacc, input logic ready);
        if_id_instruction = instr;
        id_ex_memread     = memread;
        id_ex_rd          = rd;
        id_ex_muldiv      = md;
        id_ex_is_div      = isdiv;
        ex_redirect       = redir;
        ex_mem_memaccess  = memacc;
        dmem_ready        = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

        // Reset state
        idle();
        #2;
        checkOutput("rst_pc_write", 32'(pc_write), 32'd0);
        checkOutput("rst_if_id_flush", 32'(if_id_flush), 32'd1);
        checkOutput("rst_mem_wb_flush", 32'(mem_wb_flush), 32'd1);
        checkOutput("rst_stall", stall_cycles, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Load-use bubble for one cycle
        applyStimulus(ADD_X6, 1, 5'd5, 0, 0, 0, 0, 1);
        #2;
        checkOutput("lu_pc_write", 32'(pc_write), 32'd0);
        checkOutput("lu_if_id_write", 32'(if_id_write), 32'd0);
        checkOutput("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        tick();
        applyStimulus(ADD_X6, 0, 5'd0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("lu_release", 32'(pc_write), 32'd1);
        checkOutput("lu_stall", stall_cycles, 32'd1);
        tick();
        applyStimulus(ADD_X6, 1, 5'd0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("lu_rd0", 32'(pc_write), 32'd1);
        tick();
        applyStimulus(LUI_X5, 1, 5'd5, 0, 0, 0, 0, 1);
        #2;
        checkOutput("lu_lui", 32'(pc_write), 32'd1);
        tick();
        checkOutput("lu_stall_after", stall_cycles, 32'd1);

        // Redirect overrides a concurrent load-use
        applyStimulus(ADD_X6, 1, 5'd5, 0, 0, 1, 0, 1);
        #2;
        checkOutput("redir_if_id_flush", 32'(if_id_flush), 32'd1);
        checkOutput("redir_id_ex_flush", 32'(id_ex_flush), 32'd1);
        checkOutput("redir_pc_write", 32'(pc_write), 32'd1);
        tick();
        idle();
        #2;
        checkOutput("redir_flush_count", flush_count, 32'd1);
        checkOutput("redir_stall", stall_cycles, 32'd1);
        tick();

        // Multiply: start at cycle 0, busy 1..4, release at 4
        for (int k = 0; k <= MUL_N; k++) begin
            applyStimulus(NOP, 0, 0, 1, 0, 0, 0, 1);
            #2;
            checkOutput("mul_start", 32'(muldiv_start), (k == 0) ? 32'd1 : 32'd0);
            checkOutput("mul_busy", 32'(muldiv_busy), (k >= 1) ? 32'd1 : 32'd0);
            checkOutput("mul_pc_write", 32'(pc_write), (k == MUL_N) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        #2;
        checkOutput("mul_stall", stall_cycles, 32'd5);
        checkOutput("mul_done_busy", 32'(muldiv_busy), 32'd0);
        tick();

        // Divide with memory wait during cycles 33-35, release at 36
        for (int k = 0; k <= DIV_N + 3; k++) begin
            if (k >= 33 && k <= 35) applyStimulus(NOP, 0, 0, 1, 1, 0, 1, 0);
            else                    applyStimulus(NOP, 0, 0, 1, 1, 0, 0, 1);
            #2;
            if (k >= 33 && k <= 35) begin
                checkOutput("div_ms_ex_mem_write", 32'(ex_mem_write), 32'd0);
                checkOutput("div_ms_mem_wb_flush", 32'(mem_wb_flush), 32'd1);
                checkOutput("div_ms_busy", 32'(muldiv_busy), 32'd1);
            end
            if (k == 36) begin
                checkOutput("div_release_pc", 32'(pc_write), 32'd1);
                checkOutput("div_release_busy", 32'(muldiv_busy), 32'd1);
            end
            tick();
        end
        idle();
        #2;
        checkOutput("div_stall", stall_cycles, 32'd41);
        tick();

        // Reset mid-divide at cycle 10
        for (int k = 0; k < 10; k++) begin
            applyStimulus(NOP, 0, 0, 1, 1, 0, 0, 1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_busy", 32'(muldiv_busy), 32'd0);
        checkOutput("mrst_stall", stall_cycles, 32'd0);
        checkOutput("mrst_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}), 32'hF);
        tick();
        idle();
        tick();
        rst_n = 1'b1;
        #2;
        checkOutput("mrst_no_start", 32'(muldiv_start), 32'd0);
        checkOutput("mrst_pc_write", 32'(pc_write), 32'd1);
        tick();

        // Stall counter wrap
        applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        preloadPending = 1'b1;
        #1;
        release dut.stall_cnt_q;
        #1;
        checkOutput("wrap_preload", stall_cycles, 32'hFFFF_FFFF);
        tick();
        preloadPending = 1'b0;
        #2;
        checkOutput("wrap_zero", stall_cycles, 32'h0000_0000);
        idle();
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] instr;
            instr = $urandom;
            instr[6:0]   = ops[$urandom_range(0, 8)];
            instr[19:15] = 5'($urandom_range(0, 7));
            instr[24:20] = 5'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 299) != 0);
            applyStimulus(instr,
                          ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 7)),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the 5-stage pipelined core. It combines load-use hazard detection, EX-stage branch/jump redirects, data-memory wait states and a multi-cycle mul/div sequencer. From these it drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps stall and flush performance counters.

## Interface
Parameters:
- MUL_CYCLES, 4, EX cycles a multiply needs before its result is valid
- DIV_CYCLES, 33, EX cycles a divide/remainder needs
- CNT_W, 6, mul/div counter width; must hold DIV_CYCLES-1

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_id_instruction  in  32  instruction in ID
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of the EX instruction
- id_ex_muldiv  in  1  EX instruction is an M-extension op
- id_ex_is_div  in  1  M-op is div/divu/rem/remu
- ex_redirect  in  1  taken branch or jump resolved in EX
- ex_mem_memaccess  in  1  MEM instruction is a load or store
- dmem_ready  in  1  data memory completes the MEM access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_write  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX loads bubble
- ex_mem_write  out  1  EX/MEM enable
- ex_mem_flush  out  1  EX/MEM loads bubble
- mem_wb_flush  out  1  MEM/WB loads bubble
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit
- muldiv_busy  out  1  sequencer is in MD_WAIT
- stall_cycles  out  32  count of cycles with pc_write=0
- flush_count  out  32  count of redirect flushes

## Operation
- Load-use hazard (lu) is asserted when all of the following hold:
  - id_ex_memread=1 and id_ex_rd≠0.
  - id_ex_rd equals rs1 (bits 19:15) and rs1 is used, or id_ex_rd equals rs2 (bits 24:20) and rs2 is used.
- rs1 is used unless the opcode is 0110111, 0010111 or 1101111.
- rs2 is used only for opcodes 0110011, 0100011 and 1100011.
- Memory stall (ms): ex_mem_memaccess=1 and dmem_ready=0.
- State machine states: RUN and MD_WAIT. A down-counter cnt has width CNT_W.
- Default outputs: every write signal 1, every flush signal 0, muldiv_start 0.
- Priority from highest to lowest is ms, then mul/div, then redirect, then lu.
- ms, in any state:
  - pc_write, if_id_write, id_ex_write and ex_mem_write go to 0.
  - mem_wb_flush goes to 1.
  - All other flush outputs stay 0.
- RUN with id_ex_muldiv=1 and no ms:
  - muldiv_start=1.
  - cnt is loaded with (id_ex_is_div ? DIV_CYCLES : MUL_CYCLES)-1.
  - Next state is MD_WAIT.
  - pc_write, if_id_write and id_ex_write go to 0; ex_mem_flush goes to 1.
- MD_WAIT:
  - muldiv_busy=1.
  - cnt decrements each cycle and saturates at 0.
  - While cnt≠0, outputs are as in the start cycle.
  - When cnt=0 and there is no ms: release with default outputs, next state RUN.
  - When cnt=0 and ms is active: stay in MD_WAIT, hold cnt at 0 and apply the ms outputs.
- Redirect (RUN, no ms, no mul/div start):
  - if_id_flush=1, id_ex_flush=1, pc_write=1.
  - flush_count increments.
  - A concurrent lu is ignored.
- Load-use (RUN, none of the above):
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - The bubble lasts exactly one cycle; lu clears naturally on the next cycle.
- stall_cycles increments on every cycle with pc_write=0 while rst_n=1.
- Both performance counters wrap modulo 2^32.

## Timing
- All control outputs are combinational from the state, cnt and inputs.
- The state, cnt and the two counters register on the rising edge of clk.
- Mul/div of N cycles:
  - muldiv_start fires at cycle 0 and the release occurs at cycle N, so the result must be valid at cycle N.
  - The instruction occupies EX for N+1 cycles and inserts N bubbles into MEM.
- Reset: rst_n low immediately, without waiting for an edge:
  - Forces state RUN and cnt=0; clears stall_cycles and flush_count.
  - Forces muldiv_start=0 and muldiv_busy=0.
  - Forces pc_write, if_id_write, id_ex_write and ex_mem_write to 0.
  - Forces if_id_flush, id_ex_flush, ex_mem_flush and mem_wb_flush to 1.
- Reset asserted mid-MD_WAIT aborts the sequence. There is no muldiv_start after deassertion unless id_ex_muldiv is presented again.
- Normal operation resumes on the first rising edge of clk after rst_n deasserts.

## Test plan
- Load-use: `lw x5,0(x1)` in EX, `add x6,x5,x2` in ID:
  - Exactly one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1.
  - Repeat with id_ex_rd=0, and with `lui x5` in ID: no stall in either case.
- Redirect with concurrent lu: ex_redirect=1 and lu true in the same cycle:
  - if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count 0→1.
  - No stall.
- Multiply: id_ex_muldiv=1, is_div=0:
  - muldiv_start pulses at cycle 0; muldiv_busy is high for cycles 1-4; release at cycle 4.
  - stall_cycles=4 at cycle 5.
- Divide with memory wait:
  - Divide is started; dmem_ready=0 with ex_mem_memaccess=1 during cycles 33-35.
  - Release is delayed to cycle 36.
  - ex_mem_write=0 and mem_wb_flush=1 during cycles 33-35.
- Reset mid-divide: rst_n low at cycle 10:
  - State RUN, muldiv_busy=0 and all counters 0 immediately.
  - All flush outputs 1 while rst_n is low.
- Counter wrap: preload stall_cycles to 0xFFFFFFFF through a stalled cycle; the next stall gives 0x00000000.
